// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the multiplier sequencer state encoding.
package cpu_pkg;

  localparam logic [5:0] AND = 6'd36;
  localparam logic [5:0] OR  = 6'd37;
  localparam logic [5:0] ADD = 6'd32;
  localparam logic [5:0] SUB = 6'd34;
  localparam logic [5:0] SLT = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Handshake and result bus between the EX stage and the iterative multiplier.
interface mul_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dataA, dataB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, dataA, dataB,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/alu.sv
// Existing EX-stage ALU; the multiplier reuses it unmodified as its adder.
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero
);

  always_comb begin
    dataOut = '0;
    case (Signal)
      AND:     dataOut = dataA & dataB;
      OR:      dataOut = dataA | dataB;
      ADD:     dataOut = dataA + dataB;
      SUB:     dataOut = dataA - dataB;
      SLT:     dataOut = ($signed(dataA) < $signed(dataB)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: dataOut = '0;
    endcase
  end

  assign zero = (dataOut == '0);

endmodule

// File: rtl/mul_seq.sv
// Iterative unsigned WIDTHxWIDTH -> 2*WIDTH shift-add multiplier; one add per cycle via the shared ALU.
module mul_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zero_unused;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
  logic             last_iter;
  logic             busy;
  logic             done;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .dataA   (acc_hi),
    .dataB   (mcand),
    .Signal  (ADD),
    .dataOut (alu_out),
    .zero    (alu_zero_unused)
  );

  // The ALU has no carry-out, so recover it from the operand and sum MSBs.
  always_comb begin
    sum = acc_hi;
    c   = 1'b0;
    if (acc_lo[0]) begin
      sum = alu_out;
      c   = (acc_hi[WIDTH-1] & mcand[WIDTH-1])
          | ((acc_hi[WIDTH-1] | mcand[WIDTH-1]) & ~alu_out[WIDTH-1]);
    end
  end

  assign next_hi   = {c, sum[WIDTH-1:1]};
  assign next_lo   = {sum[0], acc_lo[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result registers only load on the final iteration, so an abandoned run never disturbs them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.dataA;
            acc_hi <= '0;
            acc_lo <= bus.dataB;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            hi_q <= next_hi;
            lo_q <= next_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: vector table, scoreboard of products, and handshake corner cases.
module tb_mul_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last_result;

  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Product scoreboard: every done pulse must match the oldest accepted operand pair.
  always @(posedge clk) begin
    logic [63:0] exp;
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no pending multiply, expected done=0");
      end else begin
        exp = sb.pop_front();
        check("product", {bus.hi, bus.lo}, exp);
      end
    end
  end

  // Called on a negedge in IDLE; returns on the negedge after the DONE->IDLE edge.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int cyc;
    int busy_n;
    int hold_bad;
    bus.start = 1'b1;
    bus.dataA = a;
    bus.dataB = b;
    sb.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    cyc      = 0;
    busy_n   = 0;
    hold_bad = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      if ({bus.hi, bus.lo} !== last_result) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd32);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd32);
    check({name, "_hold_during_run"}, 64'(hold_bad), 64'd0);
    check({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({name, "_done_single_pulse"}, 64'(bus.done), 64'd0);
    last_result = exp;
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc;
    int   done_n;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs = '{
      '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000},
      '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000},
      '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF},
      '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000},
      '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF}
    };

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    last_result = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_mul($sformatf("rand%0d", i), ra, rb, 64'(ra) * 64'(rb));
    end

    // Starts during RUN and DONE are dropped; a start held into IDLE is taken.
    bus.start = 1'b1;
    bus.dataA = 32'h0000FFFF;
    bus.dataB = 32'h00010001;
    sb.push_back(64'h00000000_FFFFFFFF);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.dataA = 32'd3;
    bus.dataB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (26) @(negedge clk);
    bus.start = 1'b1;
    bus.dataA = 32'd7;
    bus.dataB = 32'd9;
    @(negedge clk);
    check("ign_done_at_e32", 64'(bus.done), 64'd1);
    check("ign_busy_at_e32", 64'(bus.busy), 64'd0);
    bus.dataA = 32'h00010000;
    bus.dataB = 32'h00010000;
    sb.push_back(64'h00000001_00000000);
    @(negedge clk);
    check("ign_done_after_e33", 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", 64'(bus.busy), 64'd1);
    check("restart_hold", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("restart_completes", 64'(bus.done), 64'd1);
    @(negedge clk);
    last_result = 64'h00000001_00000000;

    // Asynchronous reset mid-run clears outputs at once and yields no done.
    bus.start = 1'b1;
    bus.dataA = 32'h12345678;
    bus.dataB = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_n++;
    end
    check("arst_no_done", 64'(done_n), 64'd0);
    last_result = '0;
    run_mul("after_rst_7x9", 32'd7, 32'd9, 64'd63);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
